ir_nec_decoder: RTL

//  Parametrised NEC infrared frame decoder; next generation of the car-alarm IR receive path.

---
 rtl/ir_nec_pkg.sv | 44 ++++
 rtl/ir_nec_decoder_if.sv | 13 +
 rtl/ir_nec_decoder_sync_edge.sv | 42 ++++
 rtl/ir_nec_decoder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// Shared NEC decoder types: FSM encodings, error reasons, timing windows.
package ir_nec_pkg;
  localparam int NEC_BITS = 32;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LDR_MARK  = 3'd1;
  localparam logic [2:0] ST_LDR_SPACE = 3'd2;
  localparam logic [2:0] ST_BIT_MARK  = 3'd3;
  localparam logic [2:0] ST_BIT_SPACE = 3'd4;
  localparam logic [2:0] ST_RPT_MARK  = 3'd5;

  typedef enum logic [1:0] {
    ERR_TIMEOUT       = 2'd0,
    ERR_FORMAT        = 2'd1,
    ERR_CHECKSUM      = 2'd2,
    ERR_ORPHAN_REPEAT = 2'd3
  } err_code_e;

  typedef struct packed {
    logic      valid;
    logic      rpt;
    logic      err;
    err_code_e code;
  } ir_evt_t;

  // window limits in tenths of a millisecond (inclusive)
  localparam int unsigned LDR_MARK_LO_DMS  = 80;
  localparam int unsigned LDR_MARK_HI_DMS  = 100;
  localparam int unsigned LDR_SPACE_LO_DMS = 40;
  localparam int unsigned LDR_SPACE_HI_DMS = 50;
  localparam int unsigned RPT_SPACE_LO_DMS = 18;
  localparam int unsigned RPT_SPACE_HI_DMS = 27;
  localparam int unsigned BIT_MARK_LO_DMS  = 3;
  localparam int unsigned BIT_MARK_HI_DMS  = 9;
  localparam int unsigned SPACE0_LO_DMS    = 3;
  localparam int unsigned SPACE0_HI_DMS    = 9;
  localparam int unsigned SPACE1_LO_DMS    = 13;
  localparam int unsigned SPACE1_HI_DMS    = 21;
  localparam int unsigned TIMEOUT_DMS      = 120;

  function automatic int unsigned dms2cyc(input int unsigned clk_hz, input int unsigned dms);
    return clk_hz / 10000 * dms;
  endfunction
endpackage

// File: rtl/ir_nec_decoder_if.sv
// Decoder pin input and decoded-event outputs toward the alarm command logic.
interface ir_nec_decoder_if;
  logic        iIRDA;
  logic [31:0] oDATA;
  logic        oDATA_VALID;
  logic        oREPEAT;
  logic        oERR;
  logic [1:0]  oERR_CODE;
  logic        oBUSY;

  modport master (input iIRDA, output oDATA, oDATA_VALID, oREPEAT, oERR, oERR_CODE, oBUSY);
  modport slave  (output iIRDA, input oDATA, oDATA_VALID, oREPEAT, oERR, oERR_CODE, oBUSY);
endinterface

// File: rtl/ir_nec_decoder_sync_edge.sv
// IR pin synchroniser, polarity fix-up to "mark" and registered rise/fall pulses.
module ir_sync_edge #(
  parameter int SYNC_STAGES   = 2,
  parameter int IN_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  localparam logic IDLE_LVL = (IN_ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic mark_c, mark_q, mark_d, rise_q, rise_d, fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    mark_c = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;
    mark_d = mark_c;
    rise_d = mark_c & ~mark_q;
    fall_d = ~mark_c & mark_q;
  end

  // sync chain resets to the idle pin level so reset release never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_LVL}};
      mark_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      mark_q <= mark_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame/repeat decoder: pulse-width classification FSM, repeat window, frame check.
module ir_nec_decoder
  import ir_nec_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int IN_ACTIVE_LOW = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int STRICT_ADDR   = 0,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_WIN_MS = 120
) (
  input  logic iCLK,
  input  logic iRST,
  ir_nec_decoder_if.master ir
);
  localparam int unsigned T_TIMEOUT = dms2cyc(CLK_HZ, TIMEOUT_DMS);
  localparam int          CW        = $clog2(T_TIMEOUT + 1);
  localparam int unsigned T_RPT_WIN = CLK_HZ / 1000 * REPEAT_WIN_MS;
  localparam int          RW        = $clog2(T_RPT_WIN + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [RW-1:0] rcnt_t;

  localparam cnt_t  W_TMO    = cnt_t'(T_TIMEOUT);
  localparam rcnt_t W_RWIN   = rcnt_t'(T_RPT_WIN);
  localparam cnt_t  LM_LO    = cnt_t'(dms2cyc(CLK_HZ, LDR_MARK_LO_DMS));
  localparam cnt_t  LM_HI    = cnt_t'(dms2cyc(CLK_HZ, LDR_MARK_HI_DMS));
  localparam cnt_t  LS_LO    = cnt_t'(dms2cyc(CLK_HZ, LDR_SPACE_LO_DMS));
  localparam cnt_t  LS_HI    = cnt_t'(dms2cyc(CLK_HZ, LDR_SPACE_HI_DMS));
  localparam cnt_t  RS_LO    = cnt_t'(dms2cyc(CLK_HZ, RPT_SPACE_LO_DMS));
  localparam cnt_t  RS_HI    = cnt_t'(dms2cyc(CLK_HZ, RPT_SPACE_HI_DMS));
  localparam cnt_t  BM_LO    = cnt_t'(dms2cyc(CLK_HZ, BIT_MARK_LO_DMS));
  localparam cnt_t  BM_HI    = cnt_t'(dms2cyc(CLK_HZ, BIT_MARK_HI_DMS));
  localparam cnt_t  S0_LO    = cnt_t'(dms2cyc(CLK_HZ, SPACE0_LO_DMS));
  localparam cnt_t  S0_HI    = cnt_t'(dms2cyc(CLK_HZ, SPACE0_HI_DMS));
  localparam cnt_t  S1_LO    = cnt_t'(dms2cyc(CLK_HZ, SPACE1_LO_DMS));
  localparam cnt_t  S1_HI    = cnt_t'(dms2cyc(CLK_HZ, SPACE1_HI_DMS));
  localparam logic [5:0] BC_FULL = 6'(NEC_BITS);

  function automatic logic in_win(input cnt_t w, input cnt_t lo, input cnt_t hi);
    return (w >= lo) && (w <= hi);
  endfunction

  logic rise, fall, edge_c, rpt_exp, err_v, is0, is1;
  err_code_e err_c;

  logic [2:0]  state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  rcnt_t       rcnt_q, rcnt_d;
  logic        rok_q, rok_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [31:0] data_q, data_d, odata_q, odata_d;
  ir_evt_t     evt_q, evt_d;

  ir_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IN_ACTIVE_LOW(IN_ACTIVE_LOW)) u_sync (
    .clk (iCLK),
    .rst (iRST),
    .din (ir.iIRDA),
    .rise(rise),
    .fall(fall)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    rok_d    = rok_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    odata_d  = odata_q;
    evt_d    = '0;
    err_v    = 1'b0;
    err_c    = ERR_FORMAT;
    edge_c   = rise | fall;
    is0      = in_win(cnt_q, S0_LO, S0_HI);
    is1      = in_win(cnt_q, S1_LO, S1_HI);

    if (edge_c)              cnt_d = '0;
    else if (cnt_q != W_TMO) cnt_d = cnt_q + 1'b1;

    // expiry is evaluated before any repeat acceptance in the same cycle
    rpt_exp = rok_q && (rcnt_q == W_RWIN);
    if (rpt_exp)    rok_d  = 1'b0;
    else if (rok_q) rcnt_d = rcnt_q + 1'b1;

    case (state_q)
      ST_IDLE: if (rise) state_d = ST_LDR_MARK;
      ST_LDR_MARK: if (fall) begin
        if (in_win(cnt_q, LM_LO, LM_HI)) state_d = ST_LDR_SPACE;
        else err_v = 1'b1;
      end
      ST_LDR_SPACE: if (rise) begin
        if (in_win(cnt_q, LS_LO, LS_HI)) begin
          state_d  = ST_BIT_MARK;
          bitcnt_d = '0;
        end else if ((REPEAT_EN != 0) && in_win(cnt_q, RS_LO, RS_HI)) begin
          state_d = ST_RPT_MARK;
        end else err_v = 1'b1;
      end
      ST_BIT_MARK: if (fall) begin
        if (!in_win(cnt_q, BM_LO, BM_HI)) err_v = 1'b1;
        else if (bitcnt_q != BC_FULL) state_d = ST_BIT_SPACE;
        else if ((data_q[31:24] == ~data_q[23:16]) &&
                 ((STRICT_ADDR == 0) || (data_q[15:8] == ~data_q[7:0]))) begin
          state_d     = ST_IDLE;
          odata_d     = data_q;
          evt_d.valid = 1'b1;
          rok_d       = 1'b1;
          rcnt_d      = '0;
        end else begin
          err_v = 1'b1;
          err_c = ERR_CHECKSUM;
        end
      end
      ST_BIT_SPACE: if (rise) begin
        if (is0 || is1) begin
          data_d[bitcnt_q[4:0]] = is1;
          bitcnt_d = bitcnt_q + 1'b1;
          state_d  = ST_BIT_MARK;
        end else err_v = 1'b1;
      end
      ST_RPT_MARK: if (fall) begin
        if (!in_win(cnt_q, BM_LO, BM_HI)) err_v = 1'b1;
        else if (rok_q && !rpt_exp) begin
          state_d   = ST_IDLE;
          evt_d.rpt = 1'b1;
          rok_d     = 1'b1;
          rcnt_d    = '0;
        end else begin
          err_v = 1'b1;
          err_c = ERR_ORPHAN_REPEAT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && !edge_c && (cnt_q == W_TMO)) begin
      err_v = 1'b1;
      err_c = ERR_TIMEOUT;
    end

    if (err_v) begin
      state_d    = ST_IDLE;
      evt_d      = '0;
      evt_d.err  = 1'b1;
      evt_d.code = err_c;
      rok_d      = 1'b0;
      odata_d    = odata_q;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      rok_q    <= 1'b0;
      bitcnt_q <= '0;
      data_q   <= '0;
      odata_q  <= '0;
      evt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rcnt_q   <= rcnt_d;
      rok_q    <= rok_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      odata_q  <= odata_d;
      evt_q    <= evt_d;
    end
  end

  assign ir.oDATA       = odata_q;
  assign ir.oDATA_VALID = evt_q.valid;
  assign ir.oREPEAT     = evt_q.rpt;
  assign ir.oERR        = evt_q.err;
  assign ir.oERR_CODE   = evt_q.code;
  assign ir.oBUSY       = (state_q != ST_IDLE);
endmodule
